// File: rtl/alu_issue_sched.sv
// alu_issue_sched: round-robin issue scheduler sharing one integer ALU among
// NREQ reservation-station requesters. It tracks the single in-flight op for
// mispredict kill and implements a drain/hold handshake for serializing ops.
// Optional build macro: ALU_ISSUE_PERF_EN adds saturating issue/kill counters.
module alu_issue_sched #(
  parameter int NREQ        = 4,
  parameter int SPECTAG_LEN = 5,
  parameter int IDXW        = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0]             req_specbit,
  input  logic [NREQ*SPECTAG_LEN-1:0] req_spectag,
  input  logic                        prmiss,
  input  logic [SPECTAG_LEN-1:0]      spectagfix,
  input  logic                        ex_stall,
  input  logic                        hold_req,
  output logic [NREQ-1:0]             grant,
  output logic                        issue,
  output logic [IDXW-1:0]             issue_idx,
  output logic                        ex_valid,
  output logic [IDXW-1:0]             ex_idx,
  output logic                        kill_ex,
  output logic                        hold_ack
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]                 issue_cnt,
  output logic [15:0]                 kill_cnt
`endif
);

  localparam int unsigned NR = NREQ;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HELD  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [IDXW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   ex_valid_q, ex_valid_d;
  logic [IDXW-1:0]        ex_idx_q, ex_idx_d;
  logic [SPECTAG_LEN-1:0] ex_tag_q, ex_tag_d;
  logic                   ex_spec_q, ex_spec_d;

  logic [NREQ-1:0]        killed;
  logic [NREQ-1:0]        eligible;
  logic                   run_en;
  logic                   found;
  logic [IDXW-1:0]        gnt_idx;
  logic [SPECTAG_LEN-1:0] sel_tag;
  logic                   sel_spec;

  // Requesters whose op depends on the mispredicted branch are killed.
  always_comb begin
    killed = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      killed[i] = prmiss & req_specbit[i] &
                  (|(req_spectag[i*SPECTAG_LEN +: SPECTAG_LEN] & spectagfix));
    end
  end

  // Eligibility: grants only in RUN without a pending hold, no stall, out of reset.
  always_comb begin
    eligible = req & ~killed & {NREQ{run_en & ~hold_req & ~ex_stall & reset}};
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ; first hit wins.
  always_comb begin
    int unsigned cand;
    grant    = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    sel_tag  = '0;
    sel_spec = 1'b0;
    cand     = 0;
    for (int unsigned j = 0; j < NR; j++) begin
      cand = (32'(rr_ptr_q) + j) % NR;
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gnt_idx     = IDXW'(cand);
        sel_tag     = req_spectag[cand*SPECTAG_LEN +: SPECTAG_LEN];
        sel_spec    = req_specbit[cand];
      end
    end
  end

  // Issue outputs and next pointer / in-flight stage contents.
  always_comb begin
    issue      = found;
    issue_idx  = gnt_idx;
    rr_ptr_d   = rr_ptr_q;
    if (found) begin
      rr_ptr_d = (32'(gnt_idx) == NR - 1) ? '0 : gnt_idx + 1'b1;
    end
    ex_valid_d = found;
    ex_idx_d   = gnt_idx;
    ex_tag_d   = found ? sel_tag  : ex_tag_q;
    ex_spec_d  = found ? sel_spec : ex_spec_q;
  end

  // Arbiter pointer and in-flight op registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q   <= '0;
      ex_valid_q <= 1'b0;
      ex_idx_q   <= '0;
      ex_tag_q   <= '0;
      ex_spec_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      ex_valid_q <= ex_valid_d;
      ex_idx_q   <= ex_idx_d;
      ex_tag_q   <= ex_tag_d;
      ex_spec_q  <= ex_spec_d;
    end
  end

  // Kill is advisory: the op still completes, consumers gate its writeback.
  always_comb begin
    ex_valid = ex_valid_q;
    ex_idx   = ex_idx_q;
    kill_ex  = ex_valid_q & ex_spec_q & prmiss & (|(ex_tag_q & spectagfix));
  end

  // Drain/hold FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Drain/hold FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (hold_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!hold_req)       state_d = ST_RUN;
        else if (!ex_valid_q) state_d = ST_HELD;
      end
      ST_HELD:  if (!hold_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Drain/hold FSM outputs.
  always_comb begin
    run_en   = (state_q == ST_RUN);
    hold_ack = (state_q == ST_HELD);
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] kill_cnt_q, kill_cnt_d;

  // Saturating event counters.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    kill_cnt_d  = kill_cnt_q;
    if (issue && (issue_cnt_q != '1)) issue_cnt_d = issue_cnt_q + 1'b1;
    if (kill_ex && (kill_cnt_q != '1)) kill_cnt_d = kill_cnt_q + 1'b1;
    issue_cnt = issue_cnt_q;
    kill_cnt  = kill_cnt_q;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end
`endif

endmodule

// File: doc/alu_issue_sched.md
Name: alu_issue_sched

Overview:
- Issue scheduler sharing one integer ALU execution unit among NREQ reservation-station requesters.
- Each cycle it picks at most one ready, non-killed requester by round-robin and drives the exunit's issue strobe.
- It tracks the one in-flight op for misprediction kill.
- It supports a drain/hold sequence for serializing instructions.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SPECTAG_LEN, 5, speculative tag width (one-hot branch mask).
- IDXW, 2, width of the granted index, equal to clog2(NREQ).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req  in  NREQ  requester i has a ready op.
- req_specbit  in  NREQ  op i is speculative.
- req_spectag  in  NREQ*SPECTAG_LEN  spectag of op i; slice i is [i*SPECTAG_LEN +: SPECTAG_LEN].
- prmiss  in  1  branch mispredict this cycle.
- spectagfix  in  SPECTAG_LEN  tag mask of the mispredicted branch.
- ex_stall  in  1  writeback/result bus cannot accept an ALU result next cycle.
- hold_req  in  1  serializing instruction requests an empty ALU.
- grant  out  NREQ  one-hot grant, combinational; requester dequeues on it.
- issue  out  1  OR of grant; drives the exunit issue input.
- issue_idx  out  IDXW  binary index of the grant; 0 when no grant.
- ex_valid  out  1  an op is in the exunit (registered copy of issue).
- ex_idx  out  IDXW  requester index of the in-flight op.
- kill_ex  out  1  in-flight op is killed this cycle.
- hold_ack  out  1  ALU drained and held.

Behaviour:
- Kill mask, combinational: requester i is killed when prmiss & req_specbit[i] & ((req_spectag[i] & spectagfix) != 0).
- Eligibility: eligible[i] = req[i] & ~killed[i] & ~ex_stall & (state == RUN).
- Arbitration: round-robin pointer rr_ptr (IDXW bits).
  - Search eligible starting at rr_ptr, wrapping modulo NREQ.
  - The first hit gets grant.
  - At most one grant bit is set per cycle.
- rr_ptr update: on a grant to index k, rr_ptr <= (k+1) mod NREQ. With no grant it holds. Wrap from NREQ-1 goes to 0.
- In-flight stage, registered, 1-cycle latency like the exunit busy flag:
  - ex_valid <= issue, ex_idx <= issue_idx.
  - ex_tag <= req_spectag[k] and ex_spec <= req_specbit[k] are held internally.
- kill_ex, combinational = ex_valid & ex_spec & prmiss & ((ex_tag & spectagfix) != 0). kill_ex does not clear ex_valid, because the result completes next cycle anyway; consumers gate the write with it.
- prmiss and grant in the same cycle: killed requesters are excluded before arbitration, so the grant goes to the next eligible non-killed requester.
- ex_stall = 1: no grant, rr_ptr holds, ex_valid <= 0 next cycle.
- State machine (2-bit):
  - RUN: normal. If hold_req=1, go to DRAIN. No grant is made in the transition cycle, because eligibility requires RUN and is evaluated combinationally on the current state, which then blocks.
    - Clarification: in RUN with hold_req=1, grants are suppressed in that same cycle too. eligible additionally requires ~hold_req.
  - DRAIN: no grants. When ex_valid == 0, go to HELD.
  - HELD: hold_ack=1, no grants. When hold_req=0, go to RUN.
  - hold_req dropping during DRAIN: go straight to RUN.
- Reset (reset=0, asynchronous):
  - state=RUN, rr_ptr=0, ex_valid=0, ex_idx=0, ex_tag=0, ex_spec=0.
  - Outputs: grant=0 and issue=0 (also forced while reset=0), kill_ex=0, hold_ack=0.
  - Reset mid-operation discards the in-flight op silently.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- When defined, adds output issue_cnt (32 bits) and output kill_cnt (16 bits).
  - issue_cnt increments on every issue.
  - kill_cnt increments on every kill_ex.
  - Both saturate at all-ones and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then req=4'b1111 held for 4 cycles -> grant sequence 0001, 0010, 0100, 1000; rr_ptr wraps to 0; ex_valid=1 from cycle 2.
- req=4'b1010, rr_ptr=2 -> grant=1000, issue_idx=3, next rr_ptr=0; following cycle grant=0010.
- prmiss=1, spectagfix=5'b00100, req=4'b0011, req_specbit=2'b11, req_spectag[0]=00100, req_spectag[1]=00010 -> grant=0010. If the op issued last cycle carried ex_tag=00100 with ex_spec=1, kill_ex=1.
- ex_stall=1 with req=4'b0001 for 3 cycles -> grant=0, rr_ptr unchanged. On stall release, grant=0001 the same cycle.
- hold_req=1 asserted while ex_valid=1 -> no grants, state DRAIN for 1 cycle, then HELD with hold_ack=1. hold_req=0 -> RUN and grants resume next cycle.
- reset pulsed low asynchronously mid-cycle while ex_valid=1 -> ex_valid, grant, and hold_ack go to 0 immediately; rr_ptr=0 after release.
